// File: rtl/alu_sequencer_if.sv
// Bundle of the fetch, ALU and data-memory signals around the PLC ALU sequencer.
// master = surrounding system (fetch unit, ALU, memory); slave = the sequencer.
interface alu_sequencer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic              instr_valid;
    logic              instr_ready;
    logic [15:0]       instr;
    logic [4:0]        alu_op;
    logic [DATA_W-1:0] alu_in0;
    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_out;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic [DATA_W-1:0] acc;
    logic              zero;
    logic              done;
    logic              error;

    modport master (
        output instr_valid, instr, alu_out, mem_rdata, mem_ack,
        input  instr_ready, alu_op, alu_in0, alu_in1, mem_req, mem_we, mem_addr,
               mem_wdata, acc, zero, done, error
    );

    modport slave (
        input  instr_valid, instr, alu_out, mem_rdata, mem_ack,
        output instr_ready, alu_op, alu_in0, alu_in1, mem_req, mem_we, mem_addr,
               mem_wdata, acc, zero, done, error
    );
endinterface

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 8-bit PLC ALU: fetches memory operands, drives the ALU,
// updates the accumulator or stores it, with a bounded wait on memory acknowledge.
module alu_sequencer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input logic           clk,
    input logic           rst,
    alu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRead, StExec, StWrite} state_e;

    localparam logic [4:0] OpSt        = 5'd14;
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    function automatic logic is_alu_op(input logic [4:0] op);
        case (op)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5,
            5'd7, 5'd8, 5'd9, 5'd10, 5'd13: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [4:0]        alu_op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] operand_q;
    logic [DATA_W-1:0] acc_q;
    logic              zero_q;
    logic [7:0]        cnt_q;
    logic              nop_done_q;
    logic              error_q;

    logic [4:0] opcode;
    logic       imm;
    logic       accept;
    logic       op_alu;
    logic       op_st;
    logic       mem_busy;
    logic       limit;
    logic       timeout;
    logic       unused_bits;

    assign opcode      = bus.instr[15:11];
    assign imm         = bus.instr[10];
    assign unused_bits = ^bus.instr[9:8];
    assign op_alu      = is_alu_op(opcode);
    assign op_st       = (opcode == OpSt);
    assign accept      = (state_q == StIdle) && bus.instr_valid;
    assign mem_busy    = (state_q == StRead) || (state_q == StWrite);
    assign limit       = (cnt_q == TimeoutLast);
    // An ack arriving in the last allowed cycle still completes the access.
    assign timeout     = mem_busy && !bus.mem_ack && limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (op_st) begin
                        state_d = StWrite;
                    end else if (op_alu) begin
                        state_d = imm ? StExec : StRead;
                    end
                end
            end
            StRead: begin
                if (bus.mem_ack) begin
                    state_d = StExec;
                end else if (limit) begin
                    state_d = StIdle;
                end
            end
            StWrite: begin
                if (bus.mem_ack || limit) begin
                    state_d = StIdle;
                end
            end
            StExec:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.instr_ready = (state_q == StIdle);
        bus.mem_req     = mem_busy;
        bus.mem_we      = (state_q == StWrite);
        bus.done        = nop_done_q || (state_q == StExec) ||
                          ((state_q == StWrite) && bus.mem_ack);
        bus.error       = error_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op_q   <= '0;
            addr_q     <= '0;
            operand_q  <= '0;
            acc_q      <= '0;
            zero_q     <= 1'b1;
            cnt_q      <= '0;
            nop_done_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            nop_done_q <= accept && !op_alu && !op_st;
            error_q    <= timeout;

            if (accept) begin
                alu_op_q <= opcode;
                addr_q   <= ADDR_W'(bus.instr[7:0]);
                if (op_alu && imm) begin
                    operand_q <= DATA_W'(bus.instr[7:0]);
                end
            end

            // Only entered from idle, so clearing while idle resets it on entry.
            if (state_q == StIdle) begin
                cnt_q <= '0;
            end else if (mem_busy && !bus.mem_ack && !limit) begin
                cnt_q <= cnt_q + 8'd1;
            end

            if ((state_q == StRead) && bus.mem_ack) begin
                operand_q <= bus.mem_rdata;
            end

            if (state_q == StExec) begin
                acc_q  <= bus.alu_out;
                zero_q <= (bus.alu_out == '0);
            end
        end
    end

    assign bus.alu_op    = alu_op_q;
    assign bus.alu_in0   = acc_q;
    assign bus.alu_in1   = operand_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = acc_q;
    assign bus.acc       = acc_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios then random instructions, with a stub ALU,
// a responding data memory and an instruction-level accumulator/memory model.
module tb_alu_sequencer;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;
    localparam int unsigned TO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    alu_sequencer #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stub ALU; the default arm gives NOP codes a visible result should one leak into ACC.
    function automatic logic [7:0] alu_fn(input logic [4:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        case (op)
            5'd0:    return b;
            5'd1:    return a & b;
            5'd2:    return a | b;
            5'd3:    return a ^ b;
            5'd4:    return ~a;
            5'd5:    return a + b;
            5'd7:    return a - b;
            5'd8:    return b - a;
            5'd9:    return a + 8'd1;
            5'd10:   return a - 8'd1;
            5'd13:   return {a[6:0], a[7]};
            default: return a ^ 8'hA5;
        endcase
    endfunction

    assign bus.alu_out = alu_fn(bus.alu_op, bus.alu_in0, bus.alu_in1);

    int passed = 0;
    int total  = 0;
    logic [7:0] acc_m;
    logic [7:0] mem_m [256];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge (input drive phase).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction; ackdly = request cycle carrying mem_ack (1..), 0 = never.
    task automatic issue(input logic [4:0] op, input logic imm, input logic [7:0] opnd,
                         input int ackdly);
        logic       is_alu;
        logic       is_st;
        logic [7:0] opr;
        bit         acked;
        is_alu = (op <= 5'd5) || (op >= 5'd7 && op <= 5'd10) || (op == 5'd13);
        is_st  = (op == 5'd14);
        acked  = 1'b0;
        bus.instr_valid = 1'b1;
        bus.instr       = {op, imm, 2'b00, opnd};
        #4 chk("ready_idle", bus.instr_ready, 1'b1);
        cyc();
        bus.instr_valid = 1'b0;
        bus.instr       = 16'($urandom);
        if (!is_alu && !is_st) begin
            #4;
            chk("nop_done", bus.done, 1'b1);
            chk("nop_req", bus.mem_req, 1'b0);
            chk("nop_ready", bus.instr_ready, 1'b1);
            cyc();
        end else if (is_alu && imm) begin
            opr = opnd;
            #4;
            chk("exec_done", bus.done, 1'b1);
            chk("exec_op", bus.alu_op, op);
            chk("exec_in0", bus.alu_in0, acc_m);
            chk("exec_in1", bus.alu_in1, opr);
            cyc();
            acc_m = alu_fn(op, acc_m, opr);
        end else begin
            for (int c = 1; c <= int'(TO); c++) begin
                if (c == ackdly) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = is_st ? 8'($urandom) : mem_m[opnd];
                end
                #4;
                chk("mem_req", bus.mem_req, 1'b1);
                chk("mem_we", bus.mem_we, is_st);
                chk("mem_addr", bus.mem_addr, opnd);
                chk("mem_done", bus.done, is_st && (c == ackdly));
                if (is_st) chk("mem_wdata", bus.mem_wdata, acc_m);
                cyc();
                bus.mem_ack = 1'b0;
                if (c == ackdly) begin
                    acked = 1'b1;
                    break;
                end
            end
            if (!acked) begin
                #4;
                chk("to_error", bus.error, 1'b1);
                chk("to_req", bus.mem_req, 1'b0);
                chk("to_ready", bus.instr_ready, 1'b1);
                chk("to_done", bus.done, 1'b0);
                cyc();
            end else if (is_st) begin
                mem_m[opnd] = acc_m;
            end else begin
                opr = mem_m[opnd];
                #4;
                chk("rd_exec_done", bus.done, 1'b1);
                chk("rd_exec_in1", bus.alu_in1, opr);
                cyc();
                acc_m = alu_fn(op, acc_m, opr);
            end
        end
        #4;
        chk("acc", bus.acc, acc_m);
        chk("zero", bus.zero, acc_m == 8'd0);
        chk("ready_after", bus.instr_ready, 1'b1);
        chk("done_after", bus.done, 1'b0);
        chk("error_after", bus.error, 1'b0);
        cyc();
    endtask

    task automatic chk_reset_values();
        chk("rst_acc", bus.acc, 8'd0);
        chk("rst_zero", bus.zero, 1'b1);
        chk("rst_ready", bus.instr_ready, 1'b1);
        chk("rst_req", bus.mem_req, 1'b0);
        chk("rst_we", bus.mem_we, 1'b0);
        chk("rst_addr", bus.mem_addr, 8'd0);
        chk("rst_op", bus.alu_op, 5'd0);
        chk("rst_in1", bus.alu_in1, 8'd0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_error", bus.error, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
        for (int i = 0; i < 256; i++) mem_m[i] = 8'($urandom);
        acc_m = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values();
        rst = 1'b0;
        cyc();

        issue(5'd0, 1'b1, 8'h05, 0);          // LD imm 5
        issue(5'd5, 1'b1, 8'hFB, 0);          // ADD wraps to zero
        issue(5'd9, 1'b1, 8'h77, 0);          // INC
        mem_m[8'h20] = 8'h3C;
        issue(5'd0, 1'b0, 8'h20, 3);          // LD from memory, ack on third cycle
        issue(5'd14, 1'b1, 8'h10, 2);         // ST, imm ignored
        chk("st_mem", mem_m[8'h10], 8'h3C);
        issue(5'd0, 1'b0, 8'h30, 0);          // read timeout
        issue(5'd5, 1'b0, 8'h30, int'(TO));   // ack on the limit cycle completes
        issue(5'd14, 1'b0, 8'h31, 0);         // write timeout
        issue(5'd6, 1'b0, 8'h00, 0);          // NOP

        // Reset in the middle of a read; a late ack must be ignored.
        bus.instr_valid = 1'b1;
        bus.instr       = {5'd0, 1'b0, 2'b00, 8'h44};
        #4;
        cyc();
        bus.instr_valid = 1'b0;
        #4 chk("mid_req", bus.mem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk_reset_values();
        acc_m = 8'd0;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.mem_ack = 1'b1;
        #4;
        chk("late_ack_done", bus.done, 1'b0);
        chk("late_ack_req", bus.mem_req, 1'b0);
        cyc();
        bus.mem_ack = 1'b0;
        #4 chk("late_ack_acc", bus.acc, 8'd0);
        cyc();
        issue(5'd6, 1'b0, 8'h00, 0);

        for (int n = 0; n < 60; n++) begin
            logic [4:0] op;
            logic       imm;
            logic [7:0] opnd;
            int         dly;
            op   = 5'($urandom_range(0, 31));
            imm  = 1'($urandom);
            opnd = 8'($urandom);
            dly  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
            issue(op, imm, opnd, dly);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
